// File: rtl/qpsk_bit_packer.sv
// Hard-decision QPSK symbol packer: 2 bits per symbol, MSB-first into 32-bit words, tlast flushes.
// Optional QPSK_PACK_DIFF_DECODE_EN: emit quadrant differences to remove Costas phase ambiguity.
module qpsk_bit_packer #(
  parameter int unsigned SYMS_PER_WORD = 16,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                 ce_clk,
  input  logic                 ce_rst_n,
  input  logic                 clear,
  input  logic [31:0]          i_tdata,
  input  logic                 i_tvalid,
  input  logic                 i_tlast,
  output logic                 i_tready,
  output logic [31:0]          o_tdata,
  output logic                 o_tvalid,
  output logic                 o_tlast,
  input  logic                 o_tready,
  output logic [4:0]           o_nsyms,
  output logic [CNT_WIDTH-1:0] sym_count
);

  localparam logic [3:0] LastSlot = 4'(SYMS_PER_WORD - 1);

  logic                 rdy_q;
  logic [31:0]          acc_q, acc_d;
  logic [3:0]           k_q, k_d;
  logic [31:0]          odata_q, odata_d;
  logic                 ovalid_q, ovalid_d;
  logic                 olast_q, olast_d;
  logic [4:0]           onsyms_q, onsyms_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [1:0]  dibit;
  logic        completing;
  logic        accept;
  logic [31:0] word;
  logic        unused_bits;

  assign unused_bits = ^{i_tdata[30:16], i_tdata[14:0]};

`ifdef QPSK_PACK_DIFF_DECODE_EN
  logic [1:0] prev_q, prev_d;
  logic [1:0] q_idx;

  // Quadrants counted counter-clockwise from (+,+): {Qneg, Ineg ^ Qneg}
  assign q_idx = {i_tdata[15], i_tdata[31] ^ i_tdata[15]};
  assign dibit = q_idx - prev_q;

  always_comb begin
    prev_d = prev_q;
    if (clear) begin
      prev_d = 2'd0;
    end else if (accept) begin
      prev_d = i_tlast ? 2'd0 : q_idx;
    end
  end

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      prev_q <= 2'd0;
    end else begin
      prev_q <= prev_d;
    end
  end
`else
  assign dibit = {i_tdata[31], i_tdata[15]};
`endif

  assign completing = (k_q == LastSlot) || i_tlast;
  // Only a completing symbol needs the output register, so only it can stall.
  assign i_tready   = rdy_q && !(completing && ovalid_q && !o_tready);
  assign accept     = i_tvalid && i_tready && !clear;
  assign word       = acc_q | ({dibit, 30'b0} >> {k_q, 1'b0});

  always_comb begin
    acc_d    = acc_q;
    k_d      = k_q;
    odata_d  = odata_q;
    ovalid_d = ovalid_q;
    olast_d  = olast_q;
    onsyms_d = onsyms_q;
    cnt_d    = cnt_q;
    if (clear) begin
      acc_d    = '0;
      k_d      = '0;
      odata_d  = '0;
      ovalid_d = 1'b0;
      olast_d  = 1'b0;
      onsyms_d = '0;
      cnt_d    = '0;
    end else begin
      if (ovalid_q && o_tready) begin
        ovalid_d = 1'b0;
      end
      if (accept) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (completing) begin
          odata_d  = word;
          ovalid_d = 1'b1;
          olast_d  = i_tlast;
          onsyms_d = {1'b0, k_q} + 5'd1;
          acc_d    = '0;
          k_d      = '0;
        end else begin
          acc_d = word;
          k_d   = k_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      rdy_q    <= 1'b0;
      acc_q    <= '0;
      k_q      <= '0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      olast_q  <= 1'b0;
      onsyms_q <= '0;
      cnt_q    <= '0;
    end else begin
      rdy_q    <= 1'b1;
      acc_q    <= acc_d;
      k_q      <= k_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      olast_q  <= olast_d;
      onsyms_q <= onsyms_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_tdata   = odata_q;
  assign o_tvalid  = ovalid_q;
  assign o_tlast   = olast_q;
  assign o_nsyms   = onsyms_q;
  assign sym_count = cnt_q;

endmodule

// File: tb/tb_qpsk_bit_packer.sv
// Scoreboard bench for qpsk_bit_packer: a symbol-list reference model feeds an expected-word queue.
module tb_qpsk_bit_packer;

  localparam int SPW = 16;
  localparam int CW  = 32;

  logic          ce_clk = 1'b0;
  logic          ce_rst_n;
  logic          clear;
  logic [31:0]   i_tdata;
  logic          i_tvalid;
  logic          i_tlast;
  logic          i_tready;
  logic [31:0]   o_tdata;
  logic          o_tvalid;
  logic          o_tlast;
  logic          o_tready;
  logic [4:0]    o_nsyms;
  logic [CW-1:0] sym_count;

  qpsk_bit_packer #(
    .SYMS_PER_WORD(SPW),
    .CNT_WIDTH    (CW)
  ) dut (
    .ce_clk   (ce_clk),
    .ce_rst_n (ce_rst_n),
    .clear    (clear),
    .i_tdata  (i_tdata),
    .i_tvalid (i_tvalid),
    .i_tlast  (i_tlast),
    .i_tready (i_tready),
    .o_tdata  (o_tdata),
    .o_tvalid (o_tvalid),
    .o_tlast  (o_tlast),
    .o_tready (o_tready),
    .o_nsyms  (o_nsyms),
    .sym_count(sym_count)
  );

  always #5 ce_clk = ~ce_clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [4:0]  nsyms;
  } word_t;

  word_t       sb[$];
  int          dibs[$];
  int          prev_m = 0;
  int unsigned exp_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          words_pushed = 0;
  int          words_seen = 0;
  int          sym_idx = 0;
  int          first_stall = -1;
  bit          rand_run = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int i, input int q);
    logic [15:0] a;
    logic [15:0] b;
    a = 16'(i);
    b = 16'(q);
    return {a, b};
  endfunction

  function automatic int quadrant(input logic [31:0] d);
    logic signed [15:0] si;
    logic signed [15:0] sq;
    si = d[31:16];
    sq = d[15:0];
    if (si >= 0 && sq >= 0) return 0;
    else if (si < 0 && sq >= 0) return 1;
    else if (si < 0) return 2;
    else return 3;
  endfunction

  // Reference: collect decided dibits, emit a word when full or on tlast.
  task automatic model_accept(input logic [31:0] d, input logic last);
    int          dib;
    int          q;
    word_t       w;
    q = quadrant(d);
`ifdef QPSK_PACK_DIFF_DECODE_EN
    dib    = (q - prev_m + 4) % 4;
    prev_m = last ? 0 : q;
`else
    dib = ((q == 1 || q == 2) ? 2 : 0) + ((q == 2 || q == 3) ? 1 : 0);
`endif
    dibs.push_back(dib);
    exp_cnt++;
    if (dibs.size() == SPW || last) begin
      w.data = 32'd0;
      for (int i = 0; i < dibs.size(); i++) w.data |= 32'(dibs[i]) << (30 - 2 * i);
      w.last  = last;
      w.nsyms = 5'(dibs.size());
      sb.push_back(w);
      words_pushed++;
      dibs.delete();
    end
  endtask

  always @(negedge ce_clk) begin
    if (ce_rst_n && o_tvalid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got 0x%0h, expected no word", o_tdata);
      end else begin
        check("o_tdata", 64'(o_tdata), 64'(sb[0].data));
        check("o_tlast", 64'(o_tlast), 64'(sb[0].last));
        check("o_nsyms", 64'(o_nsyms), 64'(sb[0].nsyms));
        if (o_tready) begin
          void'(sb.pop_front());
          words_seen++;
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic last);
    bit acc;
    acc      = 0;
    i_tdata  = d;
    i_tvalid = 1'b1;
    i_tlast  = last;
    for (int c = 0; c < 400 && !acc; c++) begin
      @(negedge ce_clk);
      if (i_tready) begin
        model_accept(d, last);
        acc = 1;
      end else if (first_stall < 0) begin
        first_stall = sym_idx;
      end
      @(posedge ce_clk);
      #1;
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got no i_tready, expected acceptance of symbol %0d", sym_idx);
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    sym_idx++;
  endtask

  task automatic drain();
    for (int c = 0; c < 1000 && sb.size() != 0; c++) @(posedge ce_clk);
    #1;
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1);
  end

  initial begin
    ce_rst_n = 1'b0;
    clear    = 1'b0;
    i_tdata  = '0;
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    o_tready = 1'b1;
    #1;
    check("i_tready_in_reset", 64'(i_tready), 64'd0);
    repeat (3) @(posedge ce_clk);
    #1;
    check("rst_o_tvalid", 64'(o_tvalid), 64'd0);
    check("rst_o_tlast", 64'(o_tlast), 64'd0);
    check("rst_o_tdata", 64'(o_tdata), 64'd0);
    check("rst_o_nsyms", 64'(o_nsyms), 64'd0);
    check("rst_sym_count", 64'(sym_count), 64'd0);
    @(negedge ce_clk);
    ce_rst_n = 1'b1;
    #1;
    check("i_tready_before_edge", 64'(i_tready), 64'd0);
    @(posedge ce_clk);
    #1;
    check("i_tready_after_edge", 64'(i_tready), 64'd1);

    // Full word with tlast, alternating I sign
    for (int i = 0; i < 16; i++) send(mk((i % 2 == 0) ? -100 : 100, 50), i == 15);
    drain();
    check("sym_count_16", 64'(sym_count), 64'(exp_cnt));

    // Partial flush
    send(mk(-7, -9), 1'b0);
    send(mk(7, -9), 1'b0);
    send(mk(-7, 9), 1'b1);
    drain();

    // Backpressure: first word held, stall only on the 32nd symbol
    o_tready    = 1'b0;
    first_stall = -1;
    sym_idx     = 0;
    fork
      for (int i = 0; i < 32; i++) send($urandom(), 1'b0);
      begin
        repeat (60) @(posedge ce_clk);
        #1;
        o_tready = 1'b1;
      end
    join
    check("first_stall_idx", 64'(first_stall), 64'd31);
    drain();

    // Zero boundary
    for (int i = 0; i < 16; i++) send(32'd0, 1'b0);
    drain();

    // Clear mid-word
    for (int i = 0; i < 5; i++) send($urandom(), 1'b0);
    clear = 1'b1;
    dibs.delete();
    prev_m  = 0;
    exp_cnt = 0;
    @(posedge ce_clk);
    #1;
    clear = 1'b0;
    check("clear_o_tvalid", 64'(o_tvalid), 64'd0);
    check("clear_sym_count", 64'(sym_count), 64'd0);
    check("clear_i_tready", 64'(i_tready), 64'd1);
    for (int i = 0; i < 16; i++) send($urandom(), 1'b0);
    drain();
    check("clear_then_16", 64'(sym_count), 64'd16);

    // Async reset with a word pending and a partial word
    o_tready = 1'b0;
    send($urandom(), 1'b0);
    send($urandom(), 1'b1);
    for (int i = 0; i < 3; i++) send($urandom(), 1'b0);
    @(negedge ce_clk);
    #2;
    ce_rst_n = 1'b0;
    #1;
    check("async_o_tvalid", 64'(o_tvalid), 64'd0);
    check("async_sym_count", 64'(sym_count), 64'd0);
    check("async_i_tready", 64'(i_tready), 64'd0);
    words_pushed -= sb.size();
    sb.delete();
    dibs.delete();
    prev_m   = 0;
    exp_cnt  = 0;
    o_tready = 1'b1;
    @(negedge ce_clk);
    ce_rst_n = 1'b1;
    @(posedge ce_clk);
    #1;
    check("i_tready_after_rst2", 64'(i_tready), 64'd1);

`ifdef QPSK_PACK_DIFF_DECODE_EN
    // Quadrants 0,1,2,3,0 then rotated 1,2,3,0,1
    send(mk(30, 30), 1'b0);
    send(mk(-30, 30), 1'b0);
    send(mk(-30, -30), 1'b0);
    send(mk(30, -30), 1'b0);
    send(mk(30, 30), 1'b1);
    send(mk(-30, 30), 1'b0);
    send(mk(-30, -30), 1'b0);
    send(mk(30, -30), 1'b0);
    send(mk(30, 30), 1'b0);
    send(mk(-30, 30), 1'b1);
    drain();
`endif

    // Random traffic with random backpressure and gaps
    rand_run = 1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send($urandom(), $urandom_range(0, 7) == 0);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge ce_clk);
            #1;
          end
        end
        send($urandom(), 1'b1);
        rand_run = 0;
      end
      while (rand_run) begin
        @(posedge ce_clk);
        #1;
        o_tready = 1'($urandom_range(0, 1));
      end
    join
    o_tready = 1'b1;
    drain();
    check("final_sym_count", 64'(sym_count), 64'(exp_cnt));
    check("words_seen", 64'(words_seen), 64'(words_pushed));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
